srt_div_result_stage: RTL
=========================

SRT_DIV_RESULT_STAGE -- requirements
Module: srt_div_result_stage

Interface
REQ-001 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-002 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port in_valid  in  1  upstream SRT core holds a finished quotient.
REQ-004 SHALL have port in_ready  out  1  stage can accept; transfer on in_valid & in_ready at a rising edge.
REQ-005 SHALL have port q_raw  in  27  unsigned quotient: bit 26 is the integer bit, bits 25:0 are fraction; value is in [0.5, 2).
REQ-006 SHALL have port rem_neg  in  1  final partial remainder is negative.
REQ-007 SHALL have port rem_zero  in  1  final partial remainder is zero.
REQ-008 SHALL have port exp_in  in  10  signed biased exponent (ea - eb + 127).
REQ-009 SHALL have port sign_in  in  1  result sign.
REQ-010 SHALL have port spec_nan, spec_inf, spec_zero, div_zero  in  1 each  special-case flags from the operand stage.
REQ-011 SHALL have port out_valid  out  1  result is valid.
REQ-012 SHALL have port out_ready  in  1  consumer accepts; transfer on out_valid & out_ready.
REQ-013 SHALL have port result  out  32  IEEE-754 single-precision quotient.
REQ-014 SHALL have port flags  out  5  {invalid, divzero, overflow, underflow, inexact}.

Function
REQ-015 SHALL use an FSM with states IDLE -> CORR -> RND -> OUT -> IDLE; in_ready=1 only in IDLE.
REQ-016 SHALL capture all inputs on acceptance in IDLE and ignore the inputs at all other times.
REQ-017 CORR: if rem_neg, q = q_raw - 1, otherwise q = q_raw; sticky_rem = ~rem_zero.
REQ-018 CORR: if q[26]=1, mant=q[26:3], guard=q[2], sticky=|q[1:0] | sticky_rem, and exp=exp_in.
REQ-019 CORR: if q[26]=0, mant=q[25:2], guard=q[1], sticky=q[0] | sticky_rem, and exp=exp_in-1.
REQ-020 RND: round to nearest even; increment when guard & (sticky | mant[0]). On carry-out, mant=24'h800000 and exp+1.
REQ-021 RND: inexact = guard | sticky.
REQ-022 RND: if exp >= 255, result = {sign, 8'hFF, 23'h0} with overflow=1 and inexact=1.
REQ-023 RND: if exp <= 0, result = {sign, 31'h0} (flush to zero, no denormals) with underflow=1 and inexact=1.
REQ-024 Special-case priority SHALL be spec_nan > spec_inf > spec_zero.
REQ-025 spec_nan SHALL give 32'h7FC00000 with invalid=1.
REQ-026 spec_inf SHALL give {sign, 8'hFF, 23'h0}, with divzero=div_zero.
REQ-027 spec_zero SHALL give {sign, 31'h0}.
REQ-028 When any special-case flag applies, the overflow, underflow and inexact flags SHALL be 0.
REQ-029 Special cases SHALL take the same path and latency as normal results.
REQ-030 Normal case: result = {sign, exp[7:0], mant[22:0]}.
REQ-031 out_valid=1 only in OUT, asserted at the 3rd rising edge counting the acceptance edge as the 1st.
REQ-032 result and flags SHALL be registered and held stable while out_valid=1 and out_ready=0.
REQ-033 OUT -> IDLE when out_ready=1; out_ready=1 present on the edge entering OUT is not consumed. Maximum throughput is 1 result per 4 cycles.
REQ-034 Arithmetic widths: exp arithmetic in 10-bit signed; the mantissa increment in 25 bits.

Reset
REQ-035 rst low SHALL asynchronously force: state=IDLE, in_ready=1, out_valid=0, result=32'h0, flags=5'h0, all internal registers=0.
REQ-036 Reset asserted mid-operation SHALL discard the in-flight result; no output transfer follows the release of reset.

Configuration
REQ-037 Macro SRT_DIV_EXC_FLAGS_EN defined: flags SHALL be computed and registered per REQ-020 to REQ-028.
REQ-038 Macro SRT_DIV_EXC_FLAGS_EN undefined: flags SHALL be constant 5'h0, the flag registers SHALL be absent, and result behaviour SHALL be unchanged.

Verification
REQ-039 q_raw=27'h6000000, exp_in=128, sign 0, rem_zero=1 -> result 32'h40400000, flags 0, out_valid at 3rd edge.
REQ-040 q_raw=27'h7FFFFFF, exp_in=127, rem_zero=1 -> rounding carry -> 32'h40000000, inexact=1.
REQ-041 q_raw=27'h2000000, exp_in=127 -> 32'h3F000000.
REQ-042 q_raw=27'h6000001, rem_neg=1, rem_zero=0 -> 32'h40400000, inexact=1.
REQ-043 Boundary and special cases:
- exp_in=255 with q_raw=27'h4000000 -> 32'h7F800000, overflow=1 and inexact=1.
- exp_in=1 with q_raw=27'h2000000 -> 32'h00000000, underflow=1.
- spec_nan -> 32'h7FC00000, invalid=1.
REQ-044 Handshake and reset:
- out_ready held 0 for 5 cycles -> result stable and in_ready=0 throughout.
- rst pulsed low during RND -> out_valid never rises, in_ready=1 immediately.

Source files
------------

// File: rtl/srt_div_result_stage.sv
// srt_div_result_stage
// Final stage of the SRT divider. It takes the raw quotient and remainder
// status from the SRT core, corrects the quotient and normalizes it, rounds
// to nearest-even, and packs an IEEE-754 single-precision result. It also
// resolves the special cases that the operand stage has already flagged.
//
// Build option: define SRT_DIV_EXC_FLAGS_EN to compute and register the
// exception flags. When it is not defined, flags is tied to zero, there are
// no flag registers, and the result is unchanged.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | in_ready=1; captures all inputs on in_valid
// CORR  | corrects the quotient by the remainder sign, normalizes, builds
//       | guard and sticky
// RND   | rounds to nearest-even, checks exponent range, resolves special
//       | cases, registers result and flags
// OUT   | out_valid=1; result and flags held until out_ready
module srt_div_result_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [26:0] q_raw,
    input  logic        rem_neg,
    input  logic        rem_zero,
    input  logic [9:0]  exp_in,
    input  logic        sign_in,
    input  logic        spec_nan,
    input  logic        spec_inf,
    input  logic        spec_zero,
    input  logic        div_zero,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [4:0]  flags
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CORR = 2'd1,
        ST_RND  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Operands captured at acceptance. They are held until the next acceptance.
    logic [26:0]       q_raw_q;
    logic              rem_neg_q;
    logic              rem_zero_q;
    logic signed [9:0] exp_in_q;
    logic              sign_q;
    logic              nan_q;
    logic              inf_q;
    logic              zero_q;

    // Outputs of the correction/normalization step.
    logic [23:0]       mant_d, mant_q;
    logic              guard_d, guard_q;
    logic              sticky_d, sticky_q;
    logic signed [9:0] exp_c_d, exp_c_q;

    // Intermediate values for the rounding step.
    logic [26:0]       q_corr;
    logic              sticky_rem;
    logic              round_up;
    logic [24:0]       mant_inc;
    logic [23:0]       mant_rnd;
    logic signed [9:0] exp_rnd;
    logic              is_ovf;
    logic              is_unf;

    logic [31:0]       result_d, result_q;
    logic              accept;
    logic              unused_ok;

    assign accept    = (state_q == ST_IDLE) & in_valid;
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_OUT);
    assign result    = result_q;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. The stage moves through CORR and RND unconditionally,
    // so out_valid rises on the third edge, counting the acceptance edge as
    // the first. out_ready is examined only once OUT is reached.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid)  state_d = ST_CORR;
            ST_CORR:                state_d = ST_RND;
            ST_RND:                 state_d = ST_OUT;
            ST_OUT:  if (out_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Capture the inputs on acceptance only. The inputs are ignored at all
    // other times.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_raw_q    <= '0;
            rem_neg_q  <= 1'b0;
            rem_zero_q <= 1'b0;
            exp_in_q   <= '0;
            sign_q     <= 1'b0;
            nan_q      <= 1'b0;
            inf_q      <= 1'b0;
            zero_q     <= 1'b0;
        end else if (accept) begin
            q_raw_q    <= q_raw;
            rem_neg_q  <= rem_neg;
            rem_zero_q <= rem_zero;
            exp_in_q   <= exp_in;
            sign_q     <= sign_in;
            nan_q      <= spec_nan;
            inf_q      <= spec_inf;
            zero_q     <= spec_zero;
        end
    end

    // Correction and normalization. A negative final remainder means the SRT
    // quotient is one ulp too large. A nonzero remainder feeds the sticky bit.
    always_comb begin
        q_corr     = rem_neg_q ? (q_raw_q - 27'd1) : q_raw_q;
        sticky_rem = ~rem_zero_q;
        mant_d     = q_corr[25:2];
        guard_d    = q_corr[1];
        sticky_d   = q_corr[0] | sticky_rem;
        exp_c_d    = exp_in_q - 10'sd1;
        if (q_corr[26]) begin
            mant_d   = q_corr[26:3];
            guard_d  = q_corr[2];
            sticky_d = (|q_corr[1:0]) | sticky_rem;
            exp_c_d  = exp_in_q;
        end
    end

    // Register the normalized mantissa while in CORR.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mant_q   <= '0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            exp_c_q  <= '0;
        end else if (state_q == ST_CORR) begin
            mant_q   <= mant_d;
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
            exp_c_q  <= exp_c_d;
        end
    end

    // Round to nearest-even. A carry out of the 24-bit mantissa renormalizes
    // it to 1.0 and bumps the exponent. The range checks then apply to the
    // rounded exponent.
    always_comb begin
        round_up = guard_q & (sticky_q | mant_q[0]);
        mant_inc = {1'b0, mant_q} + {24'd0, round_up};
        mant_rnd = mant_inc[23:0];
        exp_rnd  = exp_c_q;
        if (mant_inc[24]) begin
            mant_rnd = 24'h800000;
            exp_rnd  = exp_c_q + 10'sd1;
        end
        is_ovf = (exp_rnd >= 10'sd255);
        is_unf = (exp_rnd <= 10'sd0);
    end

    // Pack the result. Special cases override everything. NaN has priority
    // over infinity, and infinity has priority over zero.
    always_comb begin
        result_d = {sign_q, exp_rnd[7:0], mant_rnd[22:0]};
        if (is_ovf) begin
            result_d = {sign_q, 8'hFF, 23'h0};
        end else if (is_unf) begin
            result_d = {sign_q, 31'h0};
        end
        if (nan_q) begin
            result_d = 32'h7FC00000;
        end else if (inf_q) begin
            result_d = {sign_q, 8'hFF, 23'h0};
        end else if (zero_q) begin
            result_d = {sign_q, 31'h0};
        end
    end

    // Result register. It loads when leaving RND and holds through OUT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_q <= '0;
        end else if (state_q == ST_RND) begin
            result_q <= result_d;
        end
    end

`ifdef SRT_DIV_EXC_FLAGS_EN
    logic       div_zero_q;
    logic [4:0] flags_d, flags_q;
    logic       inexact;

    // Capture the divide-by-zero indication together with the other operands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_zero_q <= 1'b0;
        end else if (accept) begin
            div_zero_q <= div_zero;
        end
    end

    // Flags are ordered {invalid, divzero, overflow, underflow, inexact}.
    // Overflow and underflow always imply inexact. A special case clears the
    // arithmetic flags.
    always_comb begin
        inexact = guard_q | sticky_q;
        flags_d = {4'b0000, inexact};
        if (is_ovf) begin
            flags_d = 5'b00101;
        end else if (is_unf) begin
            flags_d = 5'b00011;
        end
        if (nan_q) begin
            flags_d = 5'b10000;
        end else if (inf_q) begin
            flags_d = {1'b0, div_zero_q, 3'b000};
        end else if (zero_q) begin
            flags_d = 5'b00000;
        end
    end

    // The flag register is updated alongside the result register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flags_q <= '0;
        end else if (state_q == ST_RND) begin
            flags_q <= flags_d;
        end
    end

    assign flags     = flags_q;
    assign unused_ok = mant_rnd[23];
`else
    assign flags     = 5'h00;
    assign unused_ok = mant_rnd[23] ^ div_zero;
`endif

endmodule
